imem_loader: RTL
================

# imem_loader

Write-side companion to the instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-addressed instruction memory, one byte per cycle, in little-endian order starting at a programmable base address. It holds the fetch stage stalled while loading, so a program can be loaded at run time instead of from initial blocks.

## Interface
Parameters:
- ADDR_W, 16: byte-address width of the instruction memory (2^16 bytes).
- CNT_W, 16: width of the word-count input.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begins a load session. Sampled in IDLE only.
- base_addr  in  ADDR_W  first byte address. Latched on an accepted start. Any alignment is allowed.
- word_count  in  CNT_W  number of words to load. Latched on an accepted start.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  loader can take a word.
- in_word  in  32  instruction word, bit 0 = LSB.
- mem_we  out  1  byte write strobe to the instruction memory.
- mem_addr  out  ADDR_W  byte address for the write.
- mem_wdata  out  8  byte data for the write.
- busy  out  1  high in any state other than IDLE.
- core_hold  out  1  equal to busy; stalls the PC register and suppresses branch updates.
- done  out  1  one-cycle pulse when a session completes.
- err  out  1  sticky address-wrap flag; cleared by rst or by an accepted start.

## Operation
- Four FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0, mem_we=0. When start=1, latch base_addr into addr_q and word_count into rem_q, and clear err.
  - If word_count≠0, go to ACCEPT.
  - If word_count=0, go to DONE.
- ACCEPT: in_ready=1. When in_valid & in_ready, capture in_word into word_q, set byte_idx=0, and go to WRITE. Otherwise stay in ACCEPT indefinitely.
- WRITE: in_ready=0, mem_we=1, mem_addr=addr_q, mem_wdata=word_q[8*byte_idx+7 : 8*byte_idx].
  - Each cycle: addr_q increments by 1 and byte_idx increments by 1.
  - After byte_idx=3, rem_q decrements by 1. If the new rem_q=0, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. If addr_q=2^ADDR_W−1 and increments, it wraps to 0 and err is set. Writing continues after the wrap.
- start is ignored while busy=1. A start on the DONE cycle is also ignored.
- in_word is ignored outside ACCEPT. The source must hold it until the handshake completes.
- rst in any state returns the FSM to IDLE at that edge. Bytes already written stay in memory. A partially captured word is discarded.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, core_hold=0, done=0, err=0. Internal: addr_q=0, rem_q=0, byte_idx=0.
- mem_we, mem_addr and mem_wdata are registered. Memory writes occur on the edge after each WRITE cycle is presented.
- Start accepted at edge T: in_ready=1 from T+1. With in_valid already high, the handshake happens at edge T+1.
- Per word: 1 ACCEPT cycle (minimum) plus 4 WRITE cycles, so throughput is 1 word per 5 cycles.
- Session of N words with the source always valid: done is high in cycle T+1+5N, and busy falls the cycle after.
- word_count=0: done pulses at T+1, and busy is high only during that cycle.
- core_hold rises in the cycle after start is accepted and falls together with busy.

## Test plan
- Single word: start, base_addr=0x0004, count=1, in_word=0x015A04B3 → bytes written B3@4, 04@5, 5A@6, 01@7; done pulses once; read-back through the instruction-memory read port gives 0x015A04B3 at PC=4.
- Multi-word with stalls: base=0x0008, count=3, words 0x00148493, 0x F0953823, 0xF1053283, with in_valid low for 2 cycles between words → 12 contiguous bytes at 0x08–0x13; no write occurs during stall cycles; done arrives exactly when the third word's last byte is written plus 1 cycle.
- Zero count and busy-start: count=0 → done at T+1 with no mem_we. During a 2-word session, pulse start with a different base → it is ignored and the addresses continue unchanged.
- Wrap: base=0xFFFE, count=1, word 0xAABBCCDD → DD@FFFE, CC@FFFF, BB@0000, AA@0001; err=1 until the next start, and that next start clears it.
- Reset mid-WRITE: assert rst after the second byte of a word → mem_we=0 on the next cycle; all outputs at reset values; the first two bytes stay in memory; a new session then runs correctly.
- Backpressure: hold in_valid=1 with changing in_word during WRITE → only the word captured at the handshake is written; in_ready stays 0 during all WRITE cycles.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-addressed
// instruction memory, one little-endian byte per cycle, starting at a
// programmable base address. Keeps the core stalled while a session runs.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a session (honoured in IDLE only)
//   base_addr        first byte address, latched on accepted start
//   word_count       number of words to load, latched on accepted start
//   in_valid/in_ready/in_word   word input stream (valid/ready)
//   mem_we/mem_addr/mem_wdata   registered byte write port
//   busy, core_hold  high whenever the loader is not idle
//   done             one-cycle pulse at the end of a session
//   err              sticky byte-address wrap flag
module imem_loader #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_word,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic              err_q, err_d;

   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next-state, datapath and next-output logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = word_count;
               err_d   = 1'b0;
               state_d = (word_count == '0) ? S_DONE : S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (in_valid && in_ready_q) begin
               word_d     = in_word;
               byte_idx_d = 2'd0;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            // addr_q always holds the address of the byte being presented.
            addr_d     = addr_q + ADDR_W'(1);
            byte_idx_d = byte_idx_q + 2'd1;
            if (addr_q == '1) begin
               err_d = 1'b1;
            end
            if (byte_idx_q == 2'd3) begin
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_d == '0) ? S_DONE : S_ACCEPT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from next-state values so they line up
      // with the state they describe.
      in_ready_d  = (state_d == S_ACCEPT);
      mem_we_d    = (state_d == S_WRITE);
      mem_addr_d  = addr_d;
      mem_wdata_d = 8'(word_d >> {byte_idx_d, 3'b000});
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         byte_idx_q  <= 2'd0;
         word_q      <= 32'd0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign core_hold = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
